magma_block_engine: RTL and testbench



---
 rtl/magma_block_engine.sv | 216 +++++++++++++++++++++
 tb/tb_magma_block_engine.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/magma_block_engine.sv
// magma_block_engine: iterative GOST R 34.12-2015 "Magma" engine.
// Processes BLOCKS independent 64-bit blocks (ECB), one Feistel round per
// clock, and presents the packed result with a one-cycle done pulse.
// Optional feature macro: MAGMA_DECRYPT_EN (when defined, the decrypt input
// selects the reversed key schedule; otherwise the engine always encrypts).
module magma_block_engine #(
  parameter int BLOCKS = 2,
  parameter int ROUNDS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  decrypt,
  input  logic [64*BLOCKS-1:0]  data_in,
  input  logic [255:0]          key,
  output logic [64*BLOCKS-1:0]  data_out,
  output logic                  done,
  output logic                  busy
);

  localparam int DW = 64 * BLOCKS;
  localparam int BW = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;

  // Eight 4-bit substitution tables pi_0..pi_7; nibble i of the word uses pi_i.
  localparam logic [3:0] SBOX [8][16] = '{
    '{4'd12, 4'd4,  4'd6,  4'd2,  4'd10, 4'd5,  4'd11, 4'd9,  4'd14, 4'd8,  4'd13, 4'd7,  4'd0,  4'd3,  4'd15, 4'd1},
    '{4'd6,  4'd8,  4'd2,  4'd3,  4'd9,  4'd10, 4'd5,  4'd12, 4'd1,  4'd14, 4'd4,  4'd7,  4'd11, 4'd13, 4'd0,  4'd15},
    '{4'd11, 4'd3,  4'd5,  4'd8,  4'd2,  4'd15, 4'd10, 4'd13, 4'd14, 4'd1,  4'd7,  4'd4,  4'd12, 4'd9,  4'd6,  4'd0},
    '{4'd12, 4'd8,  4'd2,  4'd1,  4'd13, 4'd4,  4'd15, 4'd6,  4'd7,  4'd0,  4'd10, 4'd5,  4'd3,  4'd14, 4'd9,  4'd11},
    '{4'd7,  4'd15, 4'd5,  4'd10, 4'd8,  4'd1,  4'd6,  4'd13, 4'd0,  4'd9,  4'd3,  4'd14, 4'd11, 4'd4,  4'd2,  4'd12},
    '{4'd5,  4'd13, 4'd15, 4'd6,  4'd9,  4'd2,  4'd12, 4'd10, 4'd11, 4'd7,  4'd8,  4'd1,  4'd4,  4'd3,  4'd14, 4'd0},
    '{4'd8,  4'd14, 4'd2,  4'd5,  4'd6,  4'd9,  4'd1,  4'd12, 4'd15, 4'd4,  4'd11, 4'd0,  4'd13, 4'd10, 4'd3,  4'd7},
    '{4'd1,  4'd7,  4'd14, 4'd13, 4'd0,  4'd5,  4'd8,  4'd3,  4'd4,  4'd15, 4'd10, 4'd6,  4'd9,  4'd12, 4'd11, 4'd2}
  };

  // Round function g(k,x) = S(x + k mod 2^32) <<< 11.
  function automatic logic [31:0] g_fn(input logic [31:0] k, input logic [31:0] x);
    logic [31:0] t;
    logic [31:0] s;
    t = x + k;
    s = 32'd0;
    for (int i = 0; i < 8; i++) begin
      s[4*i +: 4] = SBOX[i][t[4*i +: 4]];
    end
    return {s[20:0], s[31:21]};
  endfunction

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [31:0]     a1_q, a1_d, a0_q, a0_d;
  logic [5:0]      round_q, round_d;
  logic [BW-1:0]   blk_q, blk_d;
  logic [DW-1:0]   din_q, din_d;
  logic [DW-1:0]   hold_q, hold_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic [255:0]    key_q, key_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic [2:0]      kidx_s;
  logic [31:0]     rk_s;
  logic [31:0]     g_s;
  logic            last_round_s;
  logic            last_blk_s;
  logic [DW-1:0]   hold_upd_s;
`ifdef MAGMA_DECRYPT_EN
  logic            dec_q, dec_d;
`else
  logic            unused_decrypt_s;
  assign unused_decrypt_s = decrypt;
`endif

  assign last_round_s = (round_q == 6'(ROUNDS - 1));
  assign last_blk_s   = (blk_q == BW'(BLOCKS - 1));
  assign rk_s         = key_q[32*(7 - int'(kidx_s)) +: 32];
  assign g_s          = g_fn(rk_s, a0_q);

  // Key-schedule index: forward K1..K8 sweeps, then K8..K1 in the tail.
  always_comb begin
    kidx_s = 3'd0;
`ifdef MAGMA_DECRYPT_EN
    if (dec_q) begin
      kidx_s = (round_q < 6'd8) ? round_q[2:0] : ~round_q[2:0];
    end else begin
      kidx_s = (round_q < 6'd24) ? round_q[2:0] : ~round_q[2:0];
    end
`else
    kidx_s = (round_q < 6'd24) ? round_q[2:0] : ~round_q[2:0];
`endif
  end

  // Hold buffer with the current block's final-round result merged in.
  always_comb begin
    hold_upd_s = hold_q;
    hold_upd_s[64*int'(blk_q) +: 64] = {g_s ^ a1_q, a0_q};
  end

  // State register plus datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      a1_q    <= 32'd0;
      a0_q    <= 32'd0;
      round_q <= 6'd0;
      blk_q   <= '0;
      din_q   <= '0;
      hold_q  <= '0;
      dout_q  <= '0;
      key_q   <= 256'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MAGMA_DECRYPT_EN
      dec_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a1_q    <= a1_d;
      a0_q    <= a0_d;
      round_q <= round_d;
      blk_q   <= blk_d;
      din_q   <= din_d;
      hold_q  <= hold_d;
      dout_q  <= dout_d;
      key_q   <= key_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef MAGMA_DECRYPT_EN
      dec_q   <= dec_d;
`endif
    end
  end

  // Next-state: IDLE accepts start; RUN ends after the last round of the last block.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_round_s && last_blk_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath/output next values: latch on start, one round per cycle in RUN.
  always_comb begin
    a1_d    = a1_q;
    a0_d    = a0_q;
    round_d = round_q;
    blk_d   = blk_q;
    din_d   = din_q;
    hold_d  = hold_q;
    dout_d  = dout_q;
    key_d   = key_q;
    done_d  = 1'b0;
    busy_d  = (state_d == S_RUN);
`ifdef MAGMA_DECRYPT_EN
    dec_d   = dec_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          din_d   = data_in;
          key_d   = key;
          a1_d    = data_in[63:32];
          a0_d    = data_in[31:0];
          round_d = 6'd0;
          blk_d   = '0;
`ifdef MAGMA_DECRYPT_EN
          dec_d   = decrypt;
`endif
        end else begin
          round_d = round_q;
        end
      end
      S_RUN: begin
        if (last_round_s) begin
          // Final round has no swap; its result goes to this block's slot.
          hold_d = hold_upd_s;
          if (last_blk_s) begin
            dout_d = hold_upd_s;
            done_d = 1'b1;
          end else begin
            // Chain straight into the next block with no idle cycle.
            blk_d   = blk_q + BW'(1);
            round_d = 6'd0;
            a1_d    = din_q[64*(int'(blk_q) + 1) + 32 +: 32];
            a0_d    = din_q[64*(int'(blk_q) + 1) +: 32];
          end
        end else begin
          a1_d    = a0_q;
          a0_d    = g_s ^ a1_q;
          round_d = round_q + 6'd1;
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  assign data_out = dout_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_magma_block_engine.sv
// Self-checking bench for magma_block_engine: directed sequence plus random
// operations checked against a behavioural Magma model.
// Honours MAGMA_DECRYPT_EN for the expected decrypt behaviour.
module tb_magma_block_engine;

  logic         clk;
  logic         reset;
  logic         start;
  logic         decrypt;
  logic [127:0] data_in;
  logic [255:0] key;
  logic [127:0] data_out;
  logic         done;
  logic         busy;

  int total = 0;
  int bad   = 0;
  bit busy_ok;
  bit hold_ok;

  localparam logic [255:0] STD_KEY = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [63:0]  PT      = 64'hfedcba9876543210;
  localparam logic [63:0]  CT      = 64'h4ee901e5c2d8ca3d;

  // pi_i written as 16 nibbles, entry 0 in the most significant nibble.
  logic [63:0] pi_tab [8] = '{
    64'hC462A5B9E8D703F1, 64'h68239A5C1E47BD0F, 64'hB3582FADE174C960, 64'hC821D4F670A53E9B,
    64'h7F5A816D093EB42C, 64'h5DF692CAB78143E0, 64'h8E25691CF4B0DA37, 64'h17ED05834FA69CB2
  };

  magma_block_engine #(.BLOCKS(2), .ROUNDS(32)) dut (
    .clk(clk), .reset(reset), .start(start), .decrypt(decrypt),
    .data_in(data_in), .key(key), .data_out(data_out), .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_g(input logic [31:0] k, input logic [31:0] a);
    logic [31:0] x;
    logic [31:0] s;
    logic [63:0] row;
    int nib;
    x = a + k;
    s = 32'd0;
    for (int i = 0; i < 8; i++) begin
      nib = int'(x[4*i +: 4]);
      row = pi_tab[i];
      s[4*i +: 4] = row[4*(15 - nib) +: 4];
    end
    return (s << 11) | (s >> 21);
  endfunction

  function automatic logic [63:0] model_block(input logic [63:0] blk, input logic [255:0] k, input bit dec);
    logic [31:0] kk [8];
    logic [31:0] fwd [32];
    logic [31:0] sched [32];
    logic [31:0] a1, a0, t;
    for (int i = 0; i < 8; i++) kk[i] = k[255 - 32*i -: 32];
    for (int i = 0; i < 32; i++) fwd[i] = (i < 24) ? kk[i % 8] : kk[7 - (i % 8)];
    for (int i = 0; i < 32; i++) sched[i] = dec ? fwd[31 - i] : fwd[i];
    a1 = blk[63:32];
    a0 = blk[31:0];
    for (int i = 0; i < 32; i++) begin
      t  = a1 ^ ref_g(sched[i], a0);
      a1 = a0;
      a0 = t;
    end
    return {a0, a1};
  endfunction

  function automatic logic [127:0] model(input logic [127:0] d, input logic [255:0] k, input bit dec);
    bit eff_dec;
`ifdef MAGMA_DECRYPT_EN
    eff_dec = dec;
`else
    eff_dec = 1'b0;
`endif
    return {model_block(d[127:64], k, eff_dec), model_block(d[63:0], k, eff_dec)};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [255:0] rnd256();
    return {rnd128(), rnd128()};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [127:0] d, input logic [255:0] k, input logic dec);
    data_in = d;
    key     = k;
    decrypt = dec;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    data_in = rnd128();
    key     = rnd256();
    decrypt = ~dec;
  endtask

  // Counts cycles until done (bounded); optionally injects a start at inj_at.
  task automatic wait_done(input int inj_at, input logic [127:0] inj_data,
                           input logic [127:0] hold_val, output int lat);
    lat = 0;
    busy_ok = busy;
    hold_ok = 1'b1;
    while (lat < 100) begin
      if (lat == inj_at) begin
        start   = 1'b1;
        data_in = inj_data;
      end else begin
        start   = 1'b0;
      end
      @(negedge clk);
      lat++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
      if (data_out !== hold_val) hold_ok = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  initial begin
    int lat;
    int nd;
    logic [127:0] d1, d2, exp1, exp2, last_res;
    logic [255:0] k1, k2;
    logic dec_r;

    reset = 1'b0; start = 1'b0; decrypt = 1'b0; data_in = 128'd0; key = 256'd0;
    repeat (3) @(negedge clk);
    check("rst_data_out", data_out, 128'd0);
    check("rst_done", {127'd0, done}, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);
    reset = 1'b1;
    @(negedge clk);

    // Standard encrypt vector
    issue({PT, PT}, STD_KEY, 1'b0);
    wait_done(-1, 128'd0, 128'd0, lat);
    check("std_latency", 128'(lat), 128'd64);
    check("std_busy_run", {127'd0, busy_ok}, 128'd1);
    check("std_hold", {127'd0, hold_ok}, 128'd1);
    check("std_result", data_out, {CT, CT});
    check("std_busy_done", {127'd0, busy}, 128'd0);
    @(negedge clk);
    check("std_done_pulse", {127'd0, done}, 128'd0);
    last_res = {CT, CT};

    // Decrypt vector (encrypt when the decrypt feature is compiled out)
    issue({CT, CT}, STD_KEY, 1'b1);
    wait_done(-1, 128'd0, last_res, lat);
    check("dec_latency", 128'(lat), 128'd64);
    check("dec_hold", {127'd0, hold_ok}, 128'd1);
`ifdef MAGMA_DECRYPT_EN
    check("dec_result", data_out, {PT, PT});
`else
    check("dec_result", data_out, model({CT, CT}, STD_KEY, 1'b0));
`endif
    last_res = data_out;

    // Block ordering
    @(negedge clk);
    issue({PT, 64'd0}, STD_KEY, 1'b0);
    wait_done(-1, 128'd0, last_res, lat);
    check("order_hi", {64'd0, data_out[127:64]}, {64'd0, CT});
    check("order_lo", {64'd0, data_out[63:0]}, {64'd0, model_block(64'd0, STD_KEY, 1'b0)});
    last_res = data_out;

    // Start while busy is ignored
    @(negedge clk);
    d1 = rnd128(); k1 = rnd256(); d2 = rnd128();
    exp1 = model(d1, k1, 1'b0);
    issue(d1, k1, 1'b0);
    wait_done(10, d2, last_res, lat);
    check("busy_start_latency", 128'(lat), 128'd64);
    check("busy_start_result", data_out, exp1);
    count_dones(80, nd);
    check("busy_start_no_2nd_done", 128'(nd), 128'd0);
    last_res = exp1;

    // Reset mid-operation
    issue(rnd128(), rnd256(), 1'b0);
    repeat (30) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midrst_data_out", data_out, 128'd0);
    check("midrst_busy", {127'd0, busy}, 128'd0);
    check("midrst_done", {127'd0, done}, 128'd0);
    count_dones(80, nd);
    check("midrst_no_done", 128'(nd), 128'd0);
    d1 = rnd128(); k1 = rnd256();
    issue(d1, k1, 1'b0);
    wait_done(-1, 128'd0, 128'd0, lat);
    check("midrst_restart_latency", 128'(lat), 128'd64);
    check("midrst_restart_result", data_out, model(d1, k1, 1'b0));

    // Back-to-back: start in the done cycle
    @(negedge clk);
    d1 = rnd128(); k1 = rnd256(); d2 = rnd128(); k2 = rnd256();
    exp1 = model(d1, k1, 1'b0);
    exp2 = model(d2, k2, 1'b1);
    issue(d1, k1, 1'b0);
    wait_done(-1, 128'd0, data_out, lat);
    check("b2b_first", data_out, exp1);
    issue(d2, k2, 1'b1);
    wait_done(-1, 128'd0, exp1, lat);
    check("b2b_latency", 128'(lat), 128'd64);
    check("b2b_hold", {127'd0, hold_ok}, 128'd1);
    check("b2b_second", data_out, exp2);
    last_res = exp2;

    // Random operations, chained through the done cycle
    for (int n = 0; n < 6; n++) begin
      d1 = rnd128(); k1 = rnd256(); dec_r = 1'($urandom_range(0, 1));
      exp1 = model(d1, k1, dec_r);
      issue(d1, k1, dec_r);
      wait_done(-1, 128'd0, last_res, lat);
      check("rand_latency", 128'(lat), 128'd64);
      check("rand_hold", {127'd0, hold_ok}, 128'd1);
      check("rand_result", data_out, exp1);
      last_res = exp1;
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
